decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 167 ++++++++++++++++
 tb/tb_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Instruction decoder with a single-entry hold stage.
// A decoded instruction is presented on registered outputs and held until
// the execute stage reports completion of that opcode. A new instruction may
// be accepted on the same edge as that completion, so back-to-back operations
// incur no bubble. Opcode 0 is a NOP: accepting it clears the outputs and
// leaves the decoder idle.
module decoder #(
    parameter int BUS_WIDTH    = 32,
    parameter int OPCODE_WIDTH = 4,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    input  logic [BUS_WIDTH-1:0]    instr,
    input  logic [OPCODE_WIDTH-1:0] op_done,
    input  logic                    next_instr,
    output logic [BUS_WIDTH-1:0]    imme_value,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [ADDR_WIDTH-1:0]   rs_addr,
    output logic                    rs_addr_sel,
    output logic                    rs_addr_valid
);

    // Instruction field positions
    localparam int OPC_LSB = 28;
    localparam int RD_LSB  = 23;
    localparam int RS_LSB  = 18;
    localparam int SEL_BIT = 17;
    localparam int IMM_W   = 17;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Raw instruction fields
    logic [OPCODE_WIDTH-1:0] f_opcode_s;
    logic [ADDR_WIDTH-1:0]   f_rd_s;
    logic [ADDR_WIDTH-1:0]   f_rs_s;
    logic                    f_sel_s;
    logic [IMM_W-1:0]        f_imm_s;

    // Handshake qualifiers
    logic complete_s;
    logic accept_s;

    // Next values of the registered outputs
    logic [BUS_WIDTH-1:0]    imme_nxt_s;
    logic [OPCODE_WIDTH-1:0] opcode_nxt_s;
    logic [ADDR_WIDTH-1:0]   rd_nxt_s;
    logic [ADDR_WIDTH-1:0]   rs_nxt_s;
    logic                    sel_nxt_s;
    logic                    rs_valid_nxt_s;

    // Sign-extend the 17-bit immediate field to the bus width
    function automatic logic [BUS_WIDTH-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
        return {{(BUS_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    assign f_opcode_s = instr[OPC_LSB +: OPCODE_WIDTH];
    assign f_rd_s     = instr[RD_LSB +: ADDR_WIDTH];
    assign f_rs_s     = instr[RS_LSB +: ADDR_WIDTH];
    assign f_sel_s    = instr[SEL_BIT];
    assign f_imm_s    = instr[IMM_W-1:0];

    // The held opcode is never 0 in BUSY, so op_done of 0 can never complete
    assign complete_s = (state_r == BUSY) && (op_done == opcode);
    assign accept_s   = instr_valid && next_instr && ((state_r == IDLE) || complete_s);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a non-NOP acceptance fills the stage, completion or a NOP empties it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (f_opcode_s != {OPCODE_WIDTH{1'b0}})) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (accept_s && (f_opcode_s != {OPCODE_WIDTH{1'b0}})) begin
                    state_nxt_s = BUSY;
                end else if (complete_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output next-value logic: decode on acceptance, clear on completion/NOP/idle, else hold
    always_comb begin
        imme_nxt_s     = imme_value;
        opcode_nxt_s   = opcode;
        rd_nxt_s       = rd_addr;
        rs_nxt_s       = rs_addr;
        sel_nxt_s      = rs_addr_sel;
        rs_valid_nxt_s = rs_addr_valid;
        if (accept_s && (f_opcode_s != {OPCODE_WIDTH{1'b0}})) begin
            opcode_nxt_s = f_opcode_s;
            rd_nxt_s     = f_rd_s;
            sel_nxt_s    = f_sel_s;
            if (f_sel_s) begin
                rs_nxt_s       = {ADDR_WIDTH{1'b0}};
                rs_valid_nxt_s = 1'b0;
                imme_nxt_s     = sign_extend_imm(f_imm_s);
            end else begin
                rs_nxt_s       = f_rs_s;
                rs_valid_nxt_s = 1'b1;
                imme_nxt_s     = {BUS_WIDTH{1'b0}};
            end
        end else if (accept_s || complete_s || (state_r == IDLE)) begin
            imme_nxt_s     = {BUS_WIDTH{1'b0}};
            opcode_nxt_s   = {OPCODE_WIDTH{1'b0}};
            rd_nxt_s       = {ADDR_WIDTH{1'b0}};
            rs_nxt_s       = {ADDR_WIDTH{1'b0}};
            sel_nxt_s      = 1'b0;
            rs_valid_nxt_s = 1'b0;
        end else begin
            imme_nxt_s     = imme_value;
            opcode_nxt_s   = opcode;
            rd_nxt_s       = rd_addr;
            rs_nxt_s       = rs_addr;
            sel_nxt_s      = rs_addr_sel;
            rs_valid_nxt_s = rs_addr_valid;
        end
    end

    // Output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imme_value    <= {BUS_WIDTH{1'b0}};
            opcode        <= {OPCODE_WIDTH{1'b0}};
            rd_addr       <= {ADDR_WIDTH{1'b0}};
            rs_addr       <= {ADDR_WIDTH{1'b0}};
            rs_addr_sel   <= 1'b0;
            rs_addr_valid <= 1'b0;
        end else begin
            imme_value    <= imme_nxt_s;
            opcode        <= opcode_nxt_s;
            rd_addr       <= rd_nxt_s;
            rs_addr       <= rs_nxt_s;
            rs_addr_sel   <= sel_nxt_s;
            rs_addr_valid <= rs_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Directed testbench for the instruction decoder.
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  op_done;
    logic        next_instr;
    logic [31:0] imme_value;
    logic [3:0]  opcode;
    logic [4:0]  rd_addr;
    logic [4:0]  rs_addr;
    logic        rs_addr_sel;
    logic        rs_addr_valid;

    int total_cnt;
    int bad_cnt;

    decoder #(
        .BUS_WIDTH    (32),
        .OPCODE_WIDTH (4),
        .ADDR_WIDTH   (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .op_done       (op_done),
        .next_instr    (next_instr),
        .imme_value    (imme_value),
        .opcode        (opcode),
        .rd_addr       (rd_addr),
        .rs_addr       (rs_addr),
        .rs_addr_sel   (rs_addr_sel),
        .rs_addr_valid (rs_addr_valid)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Compare every output against the expected decode
    task automatic check_outs(input string tag, input logic [3:0] e_op, input logic [4:0] e_rd,
                              input logic [4:0] e_rs, input logic e_sel, input logic e_vld,
                              input logic [31:0] e_imm);
        check_val({tag, ".opcode"}, {28'd0, opcode}, {28'd0, e_op});
        check_val({tag, ".rd"},     {27'd0, rd_addr}, {27'd0, e_rd});
        check_val({tag, ".rs"},     {27'd0, rs_addr}, {27'd0, e_rs});
        check_val({tag, ".sel"},    {31'd0, rs_addr_sel}, {31'd0, e_sel});
        check_val({tag, ".rsvld"},  {31'd0, rs_addr_valid}, {31'd0, e_vld});
        check_val({tag, ".imm"},    imme_value, e_imm);
    endtask

    task automatic check_zero(input string tag);
        check_outs(tag, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Expected decode of 0x329C0000: register form, rd=5, rs=7
    task automatic check_op3(input string tag);
        check_outs(tag, 4'd3, 5'd5, 5'd7, 1'b0, 1'b1, 32'd0);
    endtask

    // Expected decode of 0x40BFFFFF: immediate form, rd=1, negative immediate
    task automatic check_op4(input string tag);
        check_outs(tag, 4'd4, 5'd1, 5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic n, input logic [31:0] i, input logic [3:0] d);
        instr_valid = v;
        next_instr  = n;
        instr       = i;
        op_done     = d;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        drive(1'b0, 1'b1, 32'h329C_0000, 4'd0);
        #1;
        check_zero("reset");
        step();
        step();
        check_zero("reset_clocked");
        rst_n = 1'b1;

        // Idle with a pattern on instr but valid low: nothing accepted
        step();
        check_zero("idle_novalid0");
        step();
        check_zero("idle_novalid1");

        // Register-operand decode, hold through op_done 0 and 2
        drive(1'b1, 1'b1, 32'h329C_0000, 4'd0);
        step();
        check_op3("acc_op3");
        drive(1'b0, 1'b1, 32'h0, 4'd0);
        step();
        check_op3("hold_done0");
        drive(1'b0, 1'b1, 32'h0, 4'd2);
        step();
        check_op3("hold_done2");
        // A new instruction without completion is ignored while busy
        drive(1'b1, 1'b1, 32'h40BF_FFFF, 4'd5);
        step();
        check_op3("hold_busy_ignore");
        drive(1'b0, 1'b1, 32'h0, 4'd3);
        step();
        check_zero("complete_op3");
        drive(1'b0, 1'b1, 32'h0, 4'd0);
        step();
        check_zero("idle_after_complete");

        // Immediate form with negative immediate
        drive(1'b1, 1'b1, 32'h40BF_FFFF, 4'd0);
        step();
        check_op4("acc_op4_neg");
        drive(1'b0, 1'b1, 32'h0, 4'd4);
        step();
        check_zero("complete_op4");

        // 0x4080FFFF has bit 17 clear: register form with rs=0, immediate unused
        drive(1'b1, 1'b1, 32'h4080_FFFF, 4'd0);
        step();
        check_outs("acc_4080ffff", 4'd4, 5'd1, 5'd0, 1'b0, 1'b1, 32'd0);
        // Completion with valid high but next low: clears and does not accept
        drive(1'b1, 1'b0, 32'h329C_0000, 4'd4);
        step();
        check_zero("complete_no_next");

        // 0x4082FFFF: immediate form with bit 16 clear -> positive immediate
        drive(1'b1, 1'b1, 32'h4082_FFFF, 4'd0);
        step();
        check_outs("acc_op4_pos", 4'd4, 5'd1, 5'd0, 1'b1, 1'b0, 32'h0000_FFFF);
        drive(1'b0, 1'b1, 32'h0, 4'd4);
        step();
        check_zero("complete_op4_pos");

        // Back-to-back: completion of op 3 and acceptance of op 4 on one edge
        drive(1'b1, 1'b1, 32'h329C_0000, 4'd0);
        step();
        check_op3("b2b_first");
        drive(1'b1, 1'b1, 32'h40BF_FFFF, 4'd3);
        step();
        check_op4("b2b_second");
        drive(1'b0, 1'b1, 32'h0, 4'd4);
        step();
        check_zero("b2b_complete");

        // Backpressure: valid with next low for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h329C_0000, 4'd0);
            step();
            check_zero($sformatf("backpressure%0d", i));
        end

        // NOP accepted: outputs stay 0 and the decoder stays idle (next instr accepted)
        drive(1'b1, 1'b1, 32'h0000_0000, 4'd0);
        step();
        check_zero("nop_idle");
        drive(1'b1, 1'b1, 32'h329C_0000, 4'd0);
        step();
        check_op3("after_nop_accept");

        // NOP accepted on a completion edge returns to idle
        drive(1'b1, 1'b1, 32'h0000_0000, 4'd3);
        step();
        check_zero("nop_on_complete");
        drive(1'b1, 1'b1, 32'h40BF_FFFF, 4'd0);
        step();
        check_op4("after_nop_complete");

        // Reset pulsed mid-cycle while busy clears outputs before the next edge
        drive(1'b0, 1'b1, 32'h0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_busy");
        step();
        drive(1'b1, 1'b1, 32'h329C_0000, 4'd0);
        #2;
        rst_n = 1'b1;
        check_zero("reset_release");
        // First edge after release accepts, proving the held op 4 was discarded
        step();
        check_op3("first_after_reset");
        drive(1'b0, 1'b1, 32'h0, 4'd4);
        step();
        check_op3("old_op_gone");
        drive(1'b0, 1'b1, 32'h0, 4'd3);
        step();
        check_zero("final_complete");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
